st_rd_driver: RTL and testbench
===============================

Name: st_rd_driver

Overview:
- Initiator side of the ST/RD/RES node protocol used by every generated node_* and root_* block.
- Accepts argument tuples from a host over a valid/ready request channel and drives one computation tree (CH_ST, CH_IN0..2).
- Waits for CH_RD, captures CH_RES and returns it with a cycle count and a timeout flag on a valid/ready response channel.
- Sits between the host/test harness and a root_* instance.

Parameters:
- W, 16, data width of arguments and result.
- CW, 32, width of the cycle counter RSP_CYCLES.
- TIMEOUT, 65535, maximum CH_ST-high cycles before abort; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  1  host presents ARG0..ARG2.
- REQ_READY  out  1  driver can accept a request.
- ARG0  in  W  argument mapped to CH_IN0.
- ARG1  in  W  argument mapped to CH_IN1.
- ARG2  in  W  argument mapped to CH_IN2.
- RSP_VALID  out  1  response fields are valid.
- RSP_READY  in  1  host accepts the response.
- RSP_RES  out  W  captured result; 0 on timeout.
- RSP_TIMEOUT  out  1  job aborted by timeout.
- RSP_CYCLES  out  CW  cycles CH_ST was high for this job.
- CH_ST  out  1  start to the tree; level, held until done.
- CH_RD  in  1  tree ready; CH_RES valid while high.
- CH_RES  in  W  tree result.
- CH_IN0  out  W  latched ARG0.
- CH_IN1  out  W  latched ARG1.
- CH_IN2  out  W  latched ARG2.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (sampled at a rising edge): state=IDLE. CH_ST, RSP_VALID, RSP_TIMEOUT, RSP_RES, RSP_CYCLES, CH_IN0..2 all 0.
  - REQ_READY = (state==IDLE) & !CH_RD, combinational, so it is 1 after reset once CH_RD is low.
  - Reset during RUN or DONE drops CH_ST at that edge and discards the job; no response is issued.
- IDLE:
  - On REQ_VALID & REQ_READY: latch ARG0..2 into CH_IN0..2, counter=0, go to RUN.
  - CH_ST is registered high from the next cycle.
  - A request is not accepted while CH_RD is still high; this guards against a tree that has not yet cleared.
- RUN:
  - CH_ST=1. CH_IN0..2 stable. Counter increments every RUN cycle.
  - Edge with CH_RD=1: RSP_RES<=CH_RES, RSP_CYCLES<=counter+1, RSP_TIMEOUT<=0, CH_ST<=0, RSP_VALID<=1, go to DONE.
  - If CH_RD is high on the first RUN cycle, RSP_CYCLES=1.
  - Timeout: TIMEOUT!=0, CH_RD=0 and counter+1==TIMEOUT → RSP_RES<=0, RSP_TIMEOUT<=1, RSP_CYCLES<=TIMEOUT, CH_ST<=0, go to DONE.
  - CH_RD=1 in that same cycle has priority: normal completion, no timeout.
  - With TIMEOUT=0 the counter saturates at 2^CW-1 and never wraps.
- DONE:
  - CH_ST=0; RSP_VALID=1 and all RSP_* fields held until RSP_READY.
  - On RSP_VALID & RSP_READY: RSP_VALID<=0, go to IDLE. RSP_RES/RSP_CYCLES/RSP_TIMEOUT keep their values.
  - DONE always lasts ≥1 cycle, so CH_ST is low for ≥1 cycle between jobs; the tree restarts cleanly.
- Latency:
  - Request accepted at edge t → CH_ST=1 in cycle t+1.
  - CH_RD seen at edge k → RSP_VALID=1 in cycle k+1.
  - Minimum turnaround, request accept to next REQ_READY: 3 cycles with RSP_READY tied high.
- CH_RES is sampled only in RUN with CH_RD=1; glitches on CH_RD/CH_RES outside RUN are ignored.
- One job in flight at a time; no queuing.

Test Plan:
- Reset, then idle → REQ_READY=1, CH_ST=0, RSP_VALID=0, all data outputs 0.
- ARG=(3,4,5); tree model asserts CH_RD with CH_RES=0x0010 on the 4th CH_ST cycle → CH_IN=(3,4,5) for the whole job, RSP_RES=0x0010, RSP_CYCLES=4, RSP_TIMEOUT=0, CH_ST low in the cycle RSP_VALID rises.
- TIMEOUT=8, tree never asserts CH_RD → CH_ST high for exactly 8 cycles, RSP_TIMEOUT=1, RSP_RES=0, RSP_CYCLES=8.
- TIMEOUT=8, CH_RD first rises on the 8th cycle → completion wins: RSP_TIMEOUT=0, RSP_CYCLES=8.
- RSP_READY held low 5 cycles → RSP_VALID and all fields stable; REQ_READY=0 with REQ_VALID asserted; accept occurs only after the response handshake; back-to-back jobs show ≥1 cycle CH_ST=0 between them.
- RST asserted on the 2nd RUN cycle → CH_ST=0 after that edge, no RSP_VALID; next job with ARG=(1,1,1) completes normally. Separately, CH_RD stuck high in IDLE → REQ_READY=0 until CH_RD falls.

Source files
------------

// File: rtl/st_rd_driver.sv
// Initiator for the ST/RD/RES node protocol: takes one argument tuple from the host,
// starts the computation tree, waits for ready and returns result, cycle count and timeout flag.
module st_rd_driver #(
  parameter int unsigned W       = 16,
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [W-1:0]  ARG0,
  input  logic [W-1:0]  ARG1,
  input  logic [W-1:0]  ARG2,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [W-1:0]  RSP_RES,
  output logic          RSP_TIMEOUT,
  output logic [CW-1:0] RSP_CYCLES,
  output logic          CH_ST,
  input  logic          CH_RD,
  input  logic [W-1:0]  CH_RES,
  output logic [W-1:0]  CH_IN0,
  output logic [W-1:0]  CH_IN1,
  output logic [W-1:0]  CH_IN2
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CW-1:0] TimeoutLim = CW'(TIMEOUT);
  localparam bit            TimeoutEn  = (TIMEOUT != 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]    in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      in0_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      res_q     <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in0_q     <= in0_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      res_q     <= res_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in0_d     = in0_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    res_d     = res_q;
    cycles_d  = cycles_q;
    timeout_d = timeout_q;
    // Saturate rather than wrap so an unbounded job still reports a sane count.
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    unique case (state_q)
      StIdle: begin
        if (REQ_VALID && REQ_READY) begin
          in0_d   = ARG0;
          in1_d   = ARG1;
          in2_d   = ARG2;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // Completion takes priority over a timeout landing on the same edge.
        if (CH_RD) begin
          res_d     = CH_RES;
          cycles_d  = cnt_inc;
          timeout_d = 1'b0;
          state_d   = StDone;
        end else if (TimeoutEn && (cnt_inc == TimeoutLim)) begin
          res_d     = '0;
          cycles_d  = TimeoutLim;
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (RSP_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A tree still holding CH_RD has not cleared from the previous job.
  assign REQ_READY   = (state_q == StIdle) && !CH_RD;
  assign CH_ST       = (state_q == StRun);
  assign RSP_VALID   = (state_q == StDone);
  assign RSP_RES     = res_q;
  assign RSP_TIMEOUT = timeout_q;
  assign RSP_CYCLES  = cycles_q;
  assign CH_IN0      = in0_q;
  assign CH_IN1      = in1_q;
  assign CH_IN2      = in2_q;

endmodule

// File: tb/tb_st_rd_driver.sv
// Directed bench for st_rd_driver (TIMEOUT=8): normal jobs, timeout, completion-vs-timeout
// race, response backpressure, reset mid-job and CH_RD stuck high in idle.
module tb_st_rd_driver;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [W-1:0]  arg0, arg1, arg2;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_res;
  logic          rsp_timeout;
  logic [CW-1:0] rsp_cycles;
  logic          ch_st, ch_rd;
  logic [W-1:0]  ch_res, ch_in0, ch_in1, ch_in2;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  st_rd_driver #(.W(W), .CW(CW), .TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .ARG0(arg0), .ARG1(arg1), .ARG2(arg2),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_RES(rsp_res), .RSP_TIMEOUT(rsp_timeout), .RSP_CYCLES(rsp_cycles),
    .CH_ST(ch_st), .CH_RD(ch_rd), .CH_RES(ch_res),
    .CH_IN0(ch_in0), .CH_IN1(ch_in1), .CH_IN2(ch_in2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2);
    req_valid = 1'b1;
    arg0 = a0; arg1 = a1; arg2 = a2;
    tick();
    req_valid = 1'b0;
    arg0 = 16'hffff; arg1 = 16'hffff; arg2 = 16'hffff;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; ch_rd = 1'b0; ch_res = '0;
    arg0 = '0; arg1 = '0; arg2 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ch_st", ch_st, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_ch_in", {ch_in0, ch_in1, ch_in2}, 0);

    // Job 1: CH_RD on 4th CH_ST cycle
    req(3, 4, 5);
    chk("j1_st_c1", ch_st, 1);
    chk("j1_req_ready_busy", req_ready, 0);
    for (int c = 1; c <= 4; c++) begin
      chk("j1_ch_in", {ch_in0, ch_in1, ch_in2}, {16'd3, 16'd4, 16'd5});
      chk("j1_st_hi", ch_st, 1);
      if (c == 4) begin ch_rd = 1'b1; ch_res = 16'h0010; end
      tick();
    end
    ch_rd = 1'b0; ch_res = 16'hdead;
    chk("j1_rsp_valid", rsp_valid, 1);
    chk("j1_st_low", ch_st, 0);
    chk("j1_res", rsp_res, 16'h0010);
    chk("j1_cycles", rsp_cycles, 4);
    chk("j1_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("j1_rsp_drop", rsp_valid, 0);
    chk("j1_idle_ready", req_ready, 1);
    chk("j1_res_kept", rsp_res, 16'h0010);

    // Job 2: timeout
    req(7, 8, 9);
    n = 0;
    while (ch_st && n < 20) begin n++; tick(); end
    chk("j2_st_cycles", n, 8);
    chk("j2_rsp_valid", rsp_valid, 1);
    chk("j2_timeout", rsp_timeout, 1);
    chk("j2_res", rsp_res, 0);
    chk("j2_cycles", rsp_cycles, 8);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Job 3: CH_RD on the 8th cycle beats the timeout
    req(2, 2, 2);
    for (int c = 1; c < 8; c++) tick();
    chk("j3_st_c8", ch_st, 1);
    ch_rd = 1'b1; ch_res = 16'h1234;
    tick();
    ch_rd = 1'b0; ch_res = '0;
    chk("j3_timeout", rsp_timeout, 0);
    chk("j3_cycles", rsp_cycles, 8);
    chk("j3_res", rsp_res, 16'h1234);

    // Backpressure with a pending request
    req_valid = 1'b1; arg0 = 10; arg1 = 11; arg2 = 12;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_fields", {rsp_res, rsp_cycles, rsp_timeout}, {16'h1234, 32'd8, 1'b0});
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_gap_st", ch_st, 0);
    chk("bp_in_not_taken", ch_in0, 2);
    tick();
    req_valid = 1'b0;
    chk("bp_accept_st", ch_st, 1);
    chk("bp_accept_in", {ch_in0, ch_in1, ch_in2}, {16'd10, 16'd11, 16'd12});
    ch_rd = 1'b1; ch_res = 16'h0005;
    tick();
    ch_rd = 1'b0;
    chk("b2b_cycles1", rsp_cycles, 1);
    chk("b2b_res", rsp_res, 5);
    tick();
    chk("b2b_idle", req_ready, 1);
    rsp_ready = 1'b0;

    // Reset on the 2nd RUN cycle
    req(6, 6, 6);
    tick();
    chk("rr_st_c2", ch_st, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_st_low", ch_st, 0);
    chk("rr_no_rsp", rsp_valid, 0);
    chk("rr_in_clr", ch_in0, 0);
    tick();
    chk("rr_no_rsp2", rsp_valid, 0);
    rsp_ready = 1'b1;
    req(1, 1, 1);
    chk("rr_j_in", {ch_in0, ch_in1, ch_in2}, {16'd1, 16'd1, 16'd1});
    tick();
    ch_rd = 1'b1; ch_res = 16'h0003;
    tick();
    ch_rd = 1'b0;
    chk("rr_j_valid", rsp_valid, 1);
    chk("rr_j_res", rsp_res, 3);
    chk("rr_j_cycles", rsp_cycles, 2);
    chk("rr_j_timeout", rsp_timeout, 0);
    tick();

    // CH_RD stuck high in IDLE
    ch_rd = 1'b1; req_valid = 1'b1; arg0 = 9; arg1 = 9; arg2 = 9;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stuck_req_ready", req_ready, 0);
      tick();
      chk("stuck_no_st", ch_st, 0);
    end
    ch_rd = 1'b0;
    #1;
    chk("stuck_release", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("stuck_accept_st", ch_st, 1);
    chk("stuck_accept_in", ch_in0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
